b_preadd_pipe: RTL and testbench

Pipelined B-path stage that sits directly downstream of the B-input select mux in the DSP48A1 slice model. It registers the selected 18-bit B operand (B0 stage) and optionally combines it with the D operand through an 18-bit pre-adder/subtractor. The result is registered again (B1 stage) to feed the multiplier and the BCOUT cascade. A valid bit tracks data through the configured pipeline depth so downstream stages and benches can align results.

---
 rtl/b_preadd_pipe.sv | 121 ++++++++++++
 tb/tb_b_preadd_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/b_preadd_pipe.sv
// b_preadd_pipe: B-path stage of the DSP48A1 slice model.
// Registers the selected B operand (B0), optionally pre-adds/subtracts it
// against D, then registers the result (B1) for the multiplier and the
// BCOUT cascade. A valid bit follows the data through the enabled stages.
//
// Valid semantics: there is no back-pressure. in_valid marks b_in as
// meaningful in the cycle it is sampled. out_valid marks b1_out as carrying
// such a sample. ceb = 0 freezes data and valid together, so they never skew.
module b_preadd_pipe #(
    parameter bit B0REG     = 1'b1,
    parameter bit DREG      = 1'b1,
    parameter bit OPMODEREG = 1'b1,
    parameter bit B1REG     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ceb,
    input  logic        ced,
    input  logic        ceopmode,
    input  logic [17:0] b_in,
    input  logic [17:0] d,
    input  logic [7:0]  opmode,
    input  logic        in_valid,
    output logic [17:0] b1_out,
    output logic [17:0] bcout,
    output logic        out_valid
);

    logic [17:0] b0;
    logic [17:0] d0;
    logic        sub;
    logic        pre;
    logic [17:0] pre_res;
    logic        v0;
    logic        v1;

    // Only the add/sub and pre-adder-enable bits matter to this stage.
    logic unused_opmode;
    assign unused_opmode = ^{opmode[7], opmode[5], opmode[3:0]};

    generate
        if (B0REG) begin : g_b0_reg
            // B0 register and its valid flop, both gated by ceb.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b0 <= '0;
                    v0 <= 1'b0;
                end else if (ceb) begin
                    b0 <= b_in;
                    v0 <= in_valid;
                end
            end
        end else begin : g_b0_comb
            assign b0 = b_in;
            assign v0 = in_valid;
        end

        if (DREG) begin : g_d_reg
            // D operand register with its own enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d0 <= '0;
                end else if (ced) begin
                    d0 <= d;
                end
            end
        end else begin : g_d_comb
            assign d0 = d;
        end

        if (OPMODEREG) begin : g_op_reg
            // Opmode control bits register with its own enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sub <= 1'b0;
                    pre <= 1'b0;
                end else if (ceopmode) begin
                    sub <= opmode[6];
                    pre <= opmode[4];
                end
            end
        end else begin : g_op_comb
            assign sub = opmode[6];
            assign pre = opmode[4];
        end
    endgenerate

    // Pre-adder: carry and borrow fall off the top of the 18-bit result.
    always_comb begin
        pre_res = b0;
        if (pre) begin
            if (sub) begin
                pre_res = d0 - b0;
            end else begin
                pre_res = d0 + b0;
            end
        end
    end

    generate
        if (B1REG) begin : g_b1_reg
            // B1 register and its valid flop, both gated by ceb.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b1_out <= '0;
                    v1     <= 1'b0;
                end else if (ceb) begin
                    b1_out <= pre_res;
                    v1     <= v0;
                end
            end
        end else begin : g_b1_comb
            assign b1_out = pre_res;
            assign v1     = v0;
        end
    endgenerate

    assign bcout     = b1_out;
    assign out_valid = v1;

endmodule

// File: tb/tb_b_preadd_pipe.sv
// Self-checking bench for b_preadd_pipe: a fully registered instance driven
// by directed and random traffic against a scoreboard, plus an all-bypass
// instance checked combinationally.
module tb_b_preadd_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ceb, ced, ceopmode, in_valid;
    logic [17:0] b_in, d;
    logic [7:0]  opmode;
    logic [17:0] b1_out, bcout;
    logic        out_valid;

    logic [17:0] c_b, c_d;
    logic [7:0]  c_op;
    logic        c_v;
    logic [17:0] c_b1, c_bc;
    logic        c_ov;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    int          due_q[$];
    int          ceb_cnt  = 0;
    bit          last_ceb = 1'b0;

    // Clock / reset block
    always #5 clk = ~clk;

    b_preadd_pipe dut (
        .clk(clk), .rst_n(rst_n), .ceb(ceb), .ced(ced), .ceopmode(ceopmode),
        .b_in(b_in), .d(d), .opmode(opmode), .in_valid(in_valid),
        .b1_out(b1_out), .bcout(bcout), .out_valid(out_valid)
    );

    b_preadd_pipe #(.B0REG(1'b0), .DREG(1'b0), .OPMODEREG(1'b0), .B1REG(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .ceb(1'b1), .ced(1'b1), .ceopmode(1'b1),
        .b_in(c_b), .d(c_d), .opmode(c_op), .in_valid(c_v),
        .b1_out(c_b1), .bcout(c_bc), .out_valid(c_ov)
    );

    // Reference: the arithmetic the stage is meant to perform, mod 2^18.
    function automatic logic [17:0] ref_f(input logic [17:0] b, input logic [17:0] dd,
                                          input logic [7:0] op);
        logic [17:0] r;
        if (!op[4])     r = b;
        else if (op[6]) r = 18'((int'(dd) - int'(b)) & 32'h3FFFF);
        else            r = 18'((int'(dd) + int'(b)) % 262144);
        return r;
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: values set 2 time units after an edge are sampled on the next edge.
    task automatic drive(input logic [17:0] b, input logic [17:0] dd, input logic [7:0] op,
                         input logic v, input logic ce);
        @(posedge clk);
        #2;
        b_in = b; d = dd; opmode = op; in_valid = v; ceb = ce;
    endtask

    // Directed single sample; checks the output after the second edge.
    task automatic directed(input string name, input logic [17:0] b, input logic [17:0] dd,
                            input logic [7:0] op, input logic [17:0] exp);
        drive(b, dd, op, 1'b1, 1'b1);
        drive(18'h0, 18'h0, 8'h00, 1'b0, 1'b1);
        drive(18'h0, 18'h0, 8'h00, 1'b0, 1'b1);
        chk({name, "_b1"}, b1_out, exp);
        chk({name, "_bc"}, bcout, exp);
        chk({name, "_v"}, 18'(out_valid), 18'h1);
    endtask

    // Scoreboard push: each sampled valid input is due one ceb edge later.
    always @(posedge clk) begin
        if (!rst_n) begin
            last_ceb = 1'b0;
        end else begin
            last_ceb = ceb;
            if (ceb) begin
                ceb_cnt++;
                if (in_valid) begin
                    exp_q.push_back(ref_f(b_in, d, opmode));
                    due_q.push_back(ceb_cnt + 1);
                end
            end
        end
    end

    // Monitor: after every advancing edge, pop and compare any presented result.
    always @(negedge clk) begin
        if (rst_n && last_ceb) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got b1_out=%h with nothing expected at %0t",
                             b1_out, $time);
                end else begin
                    automatic logic [17:0] e = exp_q.pop_front();
                    automatic int du = due_q.pop_front();
                    chk("sb_data", b1_out, e);
                    chk("sb_bcout", bcout, e);
                    chk("sb_latency", 18'(ceb_cnt), 18'(du));
                end
            end else if (due_q.size() > 0 && due_q[0] <= ceb_cnt) begin
                total++;
                bad++;
                $display("FAIL missing_valid: got out_valid=0 expected data %h at %0t",
                         exp_q[0], $time);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; ceb = 1'b1; ced = 1'b1; ceopmode = 1'b1;
        b_in = '0; d = '0; opmode = '0; in_valid = 1'b0;
        c_b = '0; c_d = '0; c_op = '0; c_v = 1'b0;
        #1;
        chk("reset_b1", b1_out, 18'h0);
        chk("reset_v", 18'(out_valid), 18'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed patterns
        directed("bypass", 18'h00123, 18'h2AAAA, 8'h00, 18'h00123);
        directed("add_wrap", 18'h00002, 18'h3FFFF, 8'h10, 18'h00001);
        directed("sub_borrow", 18'h00007, 18'h00005, 8'h50, 18'h3FFFE);

        // Stall: 1, 2, then three ceb=0 cycles, then 3
        drive(18'd1, 18'h0, 8'h00, 1'b1, 1'b1);
        drive(18'd2, 18'h0, 8'h00, 1'b1, 1'b1);
        drive(18'd2, 18'h0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(18'd3, 18'h0, 8'h00, 1'b1, 1'b1);
            else        drive(18'd2, 18'h0, 8'h00, 1'b1, 1'b0);
            chk("stall_hold_b1", b1_out, 18'd1);
            chk("stall_hold_v", 18'(out_valid), 18'h1);
        end
        drive(18'd0, 18'h0, 8'h00, 1'b0, 1'b1);
        chk("stall_after_b1", b1_out, 18'd2);
        repeat (3) drive(18'd0, 18'h0, 8'h00, 1'b0, 1'b1);

        // Random traffic; d/opmode only change on advancing cycles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive(18'($urandom), 18'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            else
                drive(b_in, d, opmode, in_valid, 1'b0);
        end

        // Mid-stream reset with all-ones data in flight
        drive(18'h3FFFF, 18'h0, 8'h00, 1'b1, 1'b1);
        drive(18'h3FFFF, 18'h0, 8'h00, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_b1", b1_out, 18'h0);
        chk("midreset_bc", bcout, 18'h0);
        chk("midreset_v", 18'(out_valid), 18'h0);
        exp_q.delete();
        due_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(18'h00005, 18'h0, 8'h00, 1'b1, 1'b1);
        drive(18'h0, 18'h0, 8'h00, 1'b0, 1'b1);
        chk("post_reset_v1", 18'(out_valid), 18'h0);
        drive(18'h0, 18'h0, 8'h00, 1'b0, 1'b1);
        chk("post_reset_v2", 18'(out_valid), 18'h1);
        chk("post_reset_b1", b1_out, 18'h00005);

        // Drain and confirm nothing is left outstanding
        repeat (4) drive(18'h0, 18'h0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain_empty", 18'(exp_q.size()), 18'h0);

        // All-bypass instance: same-cycle results
        c_b = 18'h00010; c_d = 18'h00020; c_op = 8'h10; c_v = 1'b1;
        #1;
        chk("comb_add", c_b1, 18'h00030);
        chk("comb_bc", c_bc, 18'h00030);
        chk("comb_v1", 18'(c_ov), 18'h1);
        c_v = 1'b0;
        #1;
        chk("comb_v0", 18'(c_ov), 18'h0);
        for (int i = 0; i < 10; i++) begin
            c_b = 18'($urandom); c_d = 18'($urandom); c_op = 8'($urandom);
            c_v = 1'($urandom_range(0, 1));
            #1;
            chk("comb_rand", c_b1, ref_f(c_b, c_d, c_op));
            chk("comb_rand_v", 18'(c_ov), 18'(c_v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
